// File: rtl/rf_decode_pkg.sv
// Shared definitions for the register-file decode stage: FSM encoding,
// opcode constants, instruction field positions and default widths.
package rf_decode_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int INSTR_WIDTH        = 32;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;
  localparam int SHAMT_WIDTH  = 5;
  localparam int IMM_WIDTH    = 16;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  localparam logic [OPCODE_WIDTH-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL   = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/rf_decode_stage_instr_field_decode.sv
// Combinational field extractor: source/destination registers, sign-extended
// immediate, opcode, funct and shift amount of a 32-bit instruction.
module instr_field_decode
  import rf_decode_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [INSTR_WIDTH-1:0]    instr,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [REG_ADDR_WIDTH-1:0] dest,
  output logic [DATA_WIDTH-1:0]     imm,
  output logic [OPCODE_WIDTH-1:0]   opcode,
  output logic [FUNCT_WIDTH-1:0]    funct,
  output logic [SHAMT_WIDTH-1:0]    shamt
);

  assign opcode = instr[OPCODE_LSB +: OPCODE_WIDTH];
  assign rs     = instr[RS_LSB +: REG_ADDR_WIDTH];
  assign rt     = instr[RT_LSB +: REG_ADDR_WIDTH];
  assign funct  = instr[FUNCT_LSB +: FUNCT_WIDTH];
  assign shamt  = instr[SHAMT_LSB +: SHAMT_WIDTH];
  assign imm    = {{(DATA_WIDTH-IMM_WIDTH){instr[IMM_LSB+IMM_WIDTH-1]}},
                   instr[IMM_LSB +: IMM_WIDTH]};

  // R-type writes rd, jal links into the all-ones register, the rest write rt.
  always_comb begin
    dest = rt;
    if (opcode == OPC_RTYPE) begin
      dest = instr[RD_LSB +: REG_ADDR_WIDTH];
    end else if (opcode == OPC_JAL) begin
      dest = '1;
    end
  end

endmodule

// File: rtl/rf_decode_stage.sv
// Decode stage in front of the 32x32 register file: sequences the read ports,
// latches operands for execute and passes writebacks through to the write port.
// Optional feature macro: DECODE_ZERO_REG_EN (register 0 hardwired to zero).
module rf_decode_stage
  import rf_decode_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INSTR_WIDTH-1:0]    instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_r1,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_r2,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0]     rf_data_w,
  output logic                      rf_read,
  output logic                      rf_write,
  input  logic [DATA_WIDTH-1:0]     rf_data_r1,
  input  logic [DATA_WIDTH-1:0]     rf_data_r2,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [DATA_WIDTH-1:0]     op_rs_data,
  output logic [DATA_WIDTH-1:0]     op_rt_data,
  output logic [DATA_WIDTH-1:0]     op_imm,
  output logic [REG_ADDR_WIDTH-1:0] op_dest,
  output logic [OPCODE_WIDTH-1:0]   op_opcode,
  output logic [FUNCT_WIDTH-1:0]    op_funct,
  output logic [SHAMT_WIDTH-1:0]    op_shamt
);

  state_t                    state;
  logic [INSTR_WIDTH-1:0]    instr_q;
  logic                      accept;
  logic [REG_ADDR_WIDTH-1:0] dec_rs;
  logic [REG_ADDR_WIDTH-1:0] dec_rt;
  logic [REG_ADDR_WIDTH-1:0] dec_dest;
  logic [DATA_WIDTH-1:0]     dec_imm;
  logic [OPCODE_WIDTH-1:0]   dec_opcode;
  logic [FUNCT_WIDTH-1:0]    dec_funct;
  logic [SHAMT_WIDTH-1:0]    dec_shamt;
  logic [DATA_WIDTH-1:0]     rs_operand;
  logic [DATA_WIDTH-1:0]     rt_operand;

  instr_field_decode #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_field_decode (
    .instr  (instr_q),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .dest   (dec_dest),
    .imm    (dec_imm),
    .opcode (dec_opcode),
    .funct  (dec_funct),
    .shamt  (dec_shamt)
  );

  // Handshakes are gated by rst_n so both readies read 0 while reset is held.
  assign instr_ready = rst_n & ((state == ST_IDLE) | ((state == ST_OUT) & op_ready));
  assign accept      = instr_valid & instr_ready;
  assign wb_ready    = rst_n & (state != ST_READ);
  assign rf_read     = (state == ST_READ);
  assign op_valid    = (state == ST_OUT);

  assign rf_addr_r1 = dec_rs;
  assign rf_addr_r2 = dec_rt;
  assign rf_addr_w  = wb_addr;
  assign rf_data_w  = wb_data;

`ifdef DECODE_ZERO_REG_EN
  assign rf_write   = wb_valid & wb_ready & (wb_addr != '0);
  assign rs_operand = (dec_rs == '0) ? '0 : rf_data_r1;
  assign rt_operand = (dec_rt == '0) ? '0 : rf_data_r2;
`else
  assign rf_write   = wb_valid & wb_ready;
  assign rs_operand = rf_data_r1;
  assign rt_operand = rf_data_r2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      instr_q    <= '0;
      op_rs_data <= '0;
      op_rt_data <= '0;
      op_imm     <= '0;
      op_dest    <= '0;
      op_opcode  <= '0;
      op_funct   <= '0;
      op_shamt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            instr_q <= instr;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          op_rs_data <= rs_operand;
          op_rt_data <= rt_operand;
          op_imm     <= dec_imm;
          op_dest    <= dec_dest;
          op_opcode  <= dec_opcode;
          op_funct   <= dec_funct;
          op_shamt   <= dec_shamt;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          // Operands stay frozen until execute takes them.
          if (op_ready) begin
            if (accept) begin
              instr_q <= instr;
              state   <= ST_READ;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rf_decode_stage.md
# rf_decode_stage

Instruction decode stage that sits directly upstream of the 32x32 register file. It accepts a 32-bit instruction and sequences the register-file read ports for rs/rt. It latches the operands together with the decoded fields and hands them to execute over a valid/ready handshake. It also arbitrates writeback requests onto the register-file write port and guarantees that RF_READ and RF_WRITE are never asserted in the same cycle.

## Interface
- DATA_WIDTH, 32, data/operand width
- REG_ADDR_WIDTH, 5, register address width
- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  asynchronous active-low reset
- INSTR  in  32  instruction word
- INSTR_VALID / INSTR_READY  in/out  1  instruction handshake
- WB_VALID / WB_READY  in/out  1  writeback handshake
- WB_ADDR  in  5  writeback register
- WB_DATA  in  32  writeback data
- RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  out  5  register-file addresses
- RF_DATA_W  out  32  register-file write data
- RF_READ, RF_WRITE  out  1  register-file strobes
- RF_DATA_R1, RF_DATA_R2  in  32  register-file read data
- OP_VALID / OP_READY  out/in  1  operand handshake to execute
- OP_RS_DATA, OP_RT_DATA  out  32  latched operands
- OP_IMM  out  32  sign-extended INSTR[15:0]
- OP_DEST  out  5  destination register
- OP_OPCODE, OP_FUNCT  out  6  INSTR[31:26], INSTR[5:0]
- OP_SHAMT  out  5  INSTR[10:6]

## Operation
- States:
  - IDLE: waiting for an instruction.
  - READ: one cycle with the register file reading.
  - OUT: holding operands for execute.
- Instruction acceptance:
  - INSTR_READY = (state==IDLE) | (state==OUT & OP_READY).
  - INSTR_VALID & INSTR_READY latches INSTR and moves to READ.
- READ state:
  - RF_READ=1; RF_ADDR_R1=INSTR[25:21]; RF_ADDR_R2=INSTR[20:16].
  - RF_DATA_R1/R2 are captured at the closing edge into OP_RS_DATA/OP_RT_DATA.
  - Decoded fields are captured at the same edge; the next state is OUT.
- OUT state:
  - OP_VALID=1; all OP_* outputs are held stable until OP_READY.
  - OP_READY without a new instruction returns to IDLE.
  - OP_READY with a new instruction goes to READ.
- Destination select:
  - opcode 0x00 → INSTR[15:11];
  - opcode 0x03 (jal) → 31;
  - otherwise INSTR[20:16].
- Writeback:
  - WB_READY = (state != READ).
  - On WB_VALID & WB_READY: RF_WRITE=1 that same cycle, with RF_ADDR_W=WB_ADDR and RF_DATA_W=WB_DATA (combinational pass-through).
  - RF_WRITE=0 otherwise.
- Invariant: RF_READ & RF_WRITE is never 1.
- Simultaneous instruction accept and writeback in IDLE/OUT:
  - Both proceed.
  - The write lands at that edge, so the following READ observes the new value.

## Timing
- Instruction accepted at edge T → RF_READ high in cycle T..T+1 → OP_VALID high from edge T+1.
- Latency: 2 cycles from accept to OP_VALID.
- Throughput: 1 instruction per 2 cycles when OP_READY stays high.
- Writeback arriving during READ stalls exactly one cycle.
- Reset (RST=0, any time, including mid-READ or mid-OUT):
  - state=IDLE;
  - OP_VALID, RF_READ, INSTR_READY, WB_READY=0;
  - all latched fields and operands = 0.
- In-flight instructions are dropped on reset; INSTR_READY rises in the first cycle after RST deasserts.

## Configuration
- DECODE_ZERO_REG_EN defined:
  - Register 0 reads as zero: OP_RS_DATA/OP_RT_DATA are forced to 0 when the source address is 0.
  - A writeback to address 0 is accepted (WB_READY handshake completes) but RF_WRITE stays 0.
- DECODE_ZERO_REG_EN undefined: register 0 behaves like any other register.

## Structure
- Shared package holds:
  - state encoding;
  - opcode constants (R-type 0x00, jal 0x03);
  - field bit positions;
  - DATA_WIDTH/REG_ADDR_WIDTH defaults.
- One sub-module: instr_field_decode, a combinational extractor producing rs, rt, dest, imm (sign-extended), opcode, funct and shamt.

## Test plan
- Reset then INSTR=0x012A4020 (add rd=8, rs=9, rt=10) with R9=5, R10=7 → RF_ADDR_R1=9, RF_ADDR_R2=10 during READ; OP_RS_DATA=5, OP_RT_DATA=7, OP_DEST=8 two cycles after accept.
- INSTR=0x2128FFFC (addi rt=8, imm=-4) → OP_IMM=0xFFFFFFFC, OP_DEST=8. INSTR=0x0C000010 (jal) → OP_DEST=31.
- WB_VALID (addr 3, data 0xDEADBEEF) asserted during READ → WB_READY=0 that cycle; RF_WRITE=1 the next cycle; RF_READ&RF_WRITE never both 1.
- Writeback to R9 in the same cycle the instruction reading R9 is accepted → OP_RS_DATA equals the new value.
- OP_READY held low for 4 cycles → OP_* outputs stable and INSTR_READY=0. Then pulse RST=0 → OP_VALID=0 immediately, and the next instruction decodes cleanly.
- With DECODE_ZERO_REG_EN: write 0x55 to R0 → RF_WRITE=0 while WB_READY=1; a later read of R0 → operand 0. Without the macro → RF_WRITE=1.
